// File: rtl/logic_shift_pkg.sv
// Shared definitions for the logic/shift execution unit:
// operation codes, engine states and op classification.
package logic_shift_pkg;

  localparam logic [3:0] OP_AND  = 4'd0;
  localparam logic [3:0] OP_OR   = 4'd1;
  localparam logic [3:0] OP_XOR  = 4'd2;
  localparam logic [3:0] OP_NOT  = 4'd3;
  localparam logic [3:0] OP_NEG  = 4'd4;
  localparam logic [3:0] OP_SHL  = 4'd5;
  localparam logic [3:0] OP_SHR  = 4'd6;
  localparam logic [3:0] OP_SHRA = 4'd7;
  localparam logic [3:0] OP_ROL  = 4'd8;
  localparam logic [3:0] OP_ROR  = 4'd9;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // True for ops that run on the iterative engine.
  function automatic logic is_shift(input logic [3:0] op);
    return (op >= OP_SHL) && (op <= OP_ROR);
  endfunction

endpackage

// File: rtl/logic_shift_unit_shift_step.sv
// One engine step: shift or rotate a value by k (0..STEP)
// positions according to the shift/rotate op.
module shift_step
  import logic_shift_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int STEP  = 1
) (
  input  logic [3:0]               i_op,
  input  logic [WIDTH-1:0]         i_val,
  input  logic [$clog2(STEP):0]    i_k,
  output logic [WIDTH-1:0]         o_res
);

  localparam int AW = $clog2(WIDTH) + 1;

  logic [AW-1:0] w_amt;
  logic [AW-1:0] w_ramt;

  // Complementary amount gives the wrapped-around part of a rotate;
  // k=0 yields WIDTH, which shifts the wrap term out entirely.
  assign w_amt  = AW'(i_k);
  assign w_ramt = AW'(WIDTH) - w_amt;

  // Select the shift/rotate flavour for this step.
  always_comb begin
    o_res = i_val;
    unique case (1'b1)
      (i_op == OP_SHL):  o_res = i_val << w_amt;
      (i_op == OP_SHR):  o_res = i_val >> w_amt;
      (i_op == OP_SHRA): o_res = WIDTH'($signed(i_val) >>> w_amt);
      (i_op == OP_ROL):  o_res = (i_val << w_amt) | (i_val >> w_ramt);
      (i_op == OP_ROR):  o_res = (i_val >> w_amt) | (i_val << w_ramt);
      default:           o_res = i_val;
    endcase
  end

endmodule

// File: rtl/logic_shift_unit.sv
// Multi-cycle logic/shift unit: single-cycle bitwise ops and an
// iterative shift/rotate engine moving STEP bits per cycle.
module logic_shift_unit
  import logic_shift_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int STEP  = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result,
  output logic             done,
  output logic             busy,
  output logic             err
);

  localparam int SW = $clog2(WIDTH);
  localparam int AW = SW + 1;
  localparam int KW = $clog2(STEP) + 1;

  state_t           r_state;
  state_t           w_state_n;
  logic [WIDTH-1:0] r_work;
  logic [WIDTH-1:0] w_work_n;
  logic [WIDTH-1:0] r_result;
  logic [WIDTH-1:0] w_result_n;
  logic [SW-1:0]    r_rem;
  logic [SW-1:0]    w_rem_n;
  logic [3:0]       r_op;
  logic [3:0]       w_op_n;
  logic             r_err;
  logic             w_err_n;

  logic [SW-1:0]    w_amt_in;
  logic [AW-1:0]    w_rem_ext;
  logic [AW-1:0]    w_k;
  logic [KW-1:0]    w_k_step;
  logic [SW-1:0]    w_rem_dec;
  logic [WIDTH-1:0] w_step;
  logic [WIDTH-1:0] w_quick;
  logic             w_bad;

  assign w_amt_in  = b[SW-1:0];
  assign w_rem_ext = {1'b0, r_rem};
  assign w_k       = (w_rem_ext < AW'(STEP)) ? w_rem_ext : AW'(STEP);
  assign w_k_step  = KW'(w_k);
  assign w_rem_dec = r_rem - SW'(w_k);

  shift_step #(
    .WIDTH (WIDTH),
    .STEP  (STEP)
  ) u_step (
    .i_op  (r_op),
    .i_val (r_work),
    .i_k   (w_k_step),
    .o_res (w_step)
  );

  // Single-cycle result for bitwise ops and zero-amount shifts.
  always_comb begin
    w_quick = '0;
    w_bad   = 1'b0;
    case (op)
      OP_AND:  w_quick = a & b;
      OP_OR:   w_quick = a | b;
      OP_XOR:  w_quick = a ^ b;
      OP_NOT:  w_quick = ~a;
      OP_NEG:  w_quick = ~a + WIDTH'(1);
      OP_SHL,
      OP_SHR,
      OP_SHRA,
      OP_ROL,
      OP_ROR:  w_quick = a;
      default: w_bad   = 1'b1;
    endcase
  end

  // Next-state and datapath updates for the engine.
  always_comb begin
    w_state_n  = r_state;
    w_work_n   = r_work;
    w_rem_n    = r_rem;
    w_op_n     = r_op;
    w_result_n = r_result;
    w_err_n    = r_err;
    unique case (r_state)
      SHIFT: begin
        w_work_n = w_step;
        w_rem_n  = w_rem_dec;
        if (w_rem_dec == '0) begin
          w_result_n = w_step;
          w_state_n  = DONE;
        end
      end
      default: begin
        w_state_n = IDLE;
        if (start) begin
          w_op_n  = op;
          w_err_n = w_bad;
          if (is_shift(op) && (w_amt_in != '0)) begin
            w_work_n  = a;
            w_rem_n   = w_amt_in;
            w_state_n = SHIFT;
          end else begin
            w_result_n = w_quick;
            w_state_n  = DONE;
          end
        end
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= IDLE;
      r_work   <= '0;
      r_rem    <= '0;
      r_op     <= '0;
      r_result <= '0;
      r_err    <= 1'b0;
    end else begin
      r_state  <= w_state_n;
      r_work   <= w_work_n;
      r_rem    <= w_rem_n;
      r_op     <= w_op_n;
      r_result <= w_result_n;
      r_err    <= w_err_n;
    end
  end

  assign result = r_result;
  assign done   = (r_state == DONE);
  assign busy   = (r_state == SHIFT);
  assign err    = r_err;

endmodule

// File: doc/logic_shift_unit.md
Name: logic_shift_unit

Overview:
Parametrised multi-cycle logic/shift execution unit for the datapath ALU. It generalises the single-function 32-bit inverter into one unit covering these operations:
- bitwise: NOT, NEG, AND, OR, XOR
- shifts and rotates: SHL, SHR, SHRA, ROL, ROR

Bitwise ops complete in one cycle. Shifts and rotates run on an iterative engine that moves STEP bits per cycle. The ALU drives the unit with a start/done handshake; the result is held for the Z register load.

Parameters:
- WIDTH, 32, operand/result width in bits (power of two, >= 8).
- STEP, 1, bits shifted per engine cycle (power of two, 1..WIDTH).

Ports:
- clk  in  1  rising-edge clock.
- reset_n  in  1  asynchronous active-low reset.
- start  in  1  request; sampled only when busy=0.
- op  in  4  operation code (package constants).
- a  in  WIDTH  operand A, and the shifted/rotated value.
- b  in  WIDTH  operand B; shift amount = b[$clog2(WIDTH)-1:0].
- result  out  WIDTH  registered result.
- done  out  1  one-cycle pulse when result is valid.
- busy  out  1  high while the engine is shifting.
- err  out  1  set with done when op is undefined.

Behaviour:
- Reset (asynchronous, reset_n=0): state=IDLE, result=0, done=0, busy=0, err=0, internal counter and work register cleared.
- States:
  - IDLE: waiting.
  - SHIFT: engine running.
  - DONE: done=1 for exactly one cycle, then IDLE.
- Start acceptance: start is accepted at a rising edge when state is IDLE or DONE (back-to-back issue allowed). In SHIFT, start is ignored; no queuing.
- Bitwise ops (NOT, NEG, AND, OR, XOR):
  - On acceptance, result is loaded and the state goes to DONE.
  - Latency is 1: done is high in the cycle after the start edge.
  - NOT = ~a. NEG = two's complement (~a + 1), wrapping modulo 2^WIDTH.
  - b is ignored for NOT and NEG.
- Shift/rotate ops, with n = amount:
  - n=0: behaves like a bitwise op; result=a, latency 1.
  - n>0: on acceptance, the work register is loaded with a, remaining=n, and the state goes to SHIFT (busy=1).
  - Each SHIFT cycle applies k = min(STEP, remaining) positions and decrements remaining by k.
  - When remaining reaches 0, result is updated from the work register and the state goes to DONE.
  - Latency = 1 + ceil(n/STEP) cycles from the start edge to done.
- Shift semantics:
  - SHL fills zeros from the LSB.
  - SHR fills zeros from the MSB.
  - SHRA replicates the sign bit, a[WIDTH-1].
  - ROL/ROR rotate; an amount mod WIDTH is implicit from the field width.
- result holds its value until the next completion. It does not change during SHIFT; it is updated only on entry to DONE.
- Undefined op: result=0, err=1 with done, latency 1. err clears when the next op is accepted.
- a, b and op are captured at acceptance; later changes have no effect on the operation in flight.
- reset_n asserted mid-SHIFT aborts immediately to the reset values; no done is produced.

Decomposition:
- Package logic_shift_pkg holds:
  - op constants: OP_AND=0, OP_OR=1, OP_XOR=2, OP_NOT=3, OP_NEG=4, OP_SHL=5, OP_SHR=6, OP_SHRA=7, OP_ROL=8, OP_ROR=9; 10–15 are undefined.
  - the state enum IDLE/SHIFT/DONE.
- One sub-module, shift_step: combinational, shifts or rotates a WIDTH-bit value by k (0..STEP) per op. The engine instantiates it once.

Test Plan (WIDTH=32, STEP=1 unless noted):
- Bitwise ops: start with op=NOT, a=32'h0000000F → done next cycle, result=32'hFFFFFFF0. NEG a=32'h00000001 → 32'hFFFFFFFF. AND a=32'hAAAAAAAA, b=32'hFFFF0000 → 32'hAAAA0000.
- SHRA: a=32'h80000000, n=4 → busy for 4 cycles, done at cycle 5, result=32'hF8000000. Same with STEP=2 → done at cycle 3, same result.
- ROL: a=32'h80000001, n=1 → 32'h00000003. ROR a=32'h00000001, n=31 → 32'h00000002 at cycle 32. SHL with n=0 → result=a at cycle 1.
- Start while busy: SHR a=32'hF0000000, n=8, then pulse start with op=NOT at cycle 3 → ignored, result=32'h00F00000, single done pulse. A start in the DONE cycle is accepted back-to-back.
- Reset mid-operation: assert reset_n=0 during SHIFT → result=0, busy=0, done=0 immediately; no done after release.
- Undefined op=15 → done with err=1, result=0; the next valid op clears err.
